// File: rtl/prs_ber_checker.sv
// PRBS-15 (x^15 + x^14 + 1) bit-error-rate checker for the decoded bit stream.
// Self-synchronises a local reference, then counts bits/errors and tracks loss of lock per window.
module prs_ber_checker #(
   parameter int unsigned CNT_WIDTH  = 32,
   parameter int unsigned SYNC_LEN   = 64,
   parameter int unsigned WINDOW_LEN = 1024,
   parameter int unsigned LOSS_THR   = 100
) (
   input  logic                 clk,
   input  logic                 nRESET,
   input  logic                 i_clear,
   input  logic                 i_vld,
   input  logic                 i_sym,
   output logic                 o_locked,
   output logic [CNT_WIDTH-1:0] o_bit_cnt,
   output logic [CNT_WIDTH-1:0] o_err_cnt,
   output logic [15:0]          o_loss_cnt,
   output logic                 o_err
);

   typedef enum logic [0:0] {
      ST_SEARCH = 1'b0,
      ST_LOCK   = 1'b1
   } state_t;

   function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v,
                                                        input logic inc);
      if (inc && (v != {CNT_WIDTH{1'b1}})) begin
         return v + CNT_WIDTH'(1);
      end else begin
         return v;
      end
   endfunction

   function automatic logic [15:0] sat_inc_16(input logic [15:0] v, input logic inc);
      if (inc && (v != 16'hFFFF)) begin
         return v + 16'd1;
      end else begin
         return v;
      end
   endfunction

   state_t                 state_q, state_d;
   logic [14:0]            sr_q, sr_d;
   logic [3:0]             fill_q, fill_d;
   logic [15:0]            match_q, match_d;
   logic [15:0]            win_bits_q, win_bits_d;
   logic [15:0]            win_err_q, win_err_d;
   logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
   logic [15:0]            loss_cnt_q, loss_cnt_d;
   logic                   locked_q, locked_d;
   logic                   err_q, err_d;

   logic                   pred_s;
   logic                   err_bit_s;
   logic                   filled_s;
   logic                   match_s;
   logic                   sync_done_s;
   logic [15:0]            win_bits_inc_s;
   logic [15:0]            win_err_inc_s;
   logic                   win_end_s;
   logic                   loss_s;

   // Reference prediction, comparison and window-boundary decode.
   always_comb begin
      pred_s         = sr_q[14] ^ sr_q[13];
      err_bit_s      = i_sym ^ pred_s;
      filled_s       = (fill_q == 4'd15);
      // An all-zero register is the PRBS lock-up state and must never count as a match.
      match_s        = filled_s && (i_sym == pred_s) && (sr_q != 15'd0);
      sync_done_s    = match_s && (match_q == 16'(SYNC_LEN - 1));
      win_bits_inc_s = win_bits_q + 16'd1;
      win_err_inc_s  = sat_inc_16(win_err_q, err_bit_s);
      win_end_s      = (win_bits_inc_s == 16'(WINDOW_LEN));
      loss_s         = win_end_s && ({16'd0, win_err_inc_s} > 32'(LOSS_THR));
   end

   // Next-state logic for search/lock tracking and the statistics counters.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      fill_d     = fill_q;
      match_d    = match_q;
      win_bits_d = win_bits_q;
      win_err_d  = win_err_q;
      bit_cnt_d  = bit_cnt_q;
      err_cnt_d  = err_cnt_q;
      loss_cnt_d = loss_cnt_q;
      locked_d   = locked_q;
      err_d      = 1'b0;

      if (i_vld) begin
         case (state_q)
            ST_SEARCH: begin
               sr_d = {sr_q[13:0], i_sym};
               if (!filled_s) begin
                  fill_d = fill_q + 4'd1;
               end else if (sync_done_s) begin
                  state_d    = ST_LOCK;
                  locked_d   = 1'b1;
                  match_d    = 16'd0;
                  win_bits_d = 16'd0;
                  win_err_d  = 16'd0;
               end else if (match_s) begin
                  match_d = match_q + 16'd1;
               end else begin
                  match_d = 16'd0;
               end
            end
            ST_LOCK: begin
               // Free-running reference: errors on the line are never absorbed.
               sr_d      = {sr_q[13:0], pred_s};
               bit_cnt_d = sat_inc_cnt(bit_cnt_q, 1'b1);
               err_cnt_d = sat_inc_cnt(err_cnt_q, err_bit_s);
               err_d     = err_bit_s;
               if (win_end_s) begin
                  win_bits_d = 16'd0;
                  win_err_d  = 16'd0;
                  if (loss_s) begin
                     state_d    = ST_SEARCH;
                     locked_d   = 1'b0;
                     loss_cnt_d = sat_inc_16(loss_cnt_q, 1'b1);
                     fill_d     = 4'd0;
                     match_d    = 16'd0;
                     sr_d       = 15'd0;
                  end else begin
                     state_d = ST_LOCK;
                  end
               end else begin
                  win_bits_d = win_bits_inc_s;
                  win_err_d  = win_err_inc_s;
               end
            end
            default: begin
               state_d  = ST_SEARCH;
               locked_d = 1'b0;
            end
         endcase
      end else begin
         err_d = 1'b0;
      end

      // Clear wins over a same-cycle increment; lock tracking is left alone.
      if (i_clear) begin
         bit_cnt_d  = {CNT_WIDTH{1'b0}};
         err_cnt_d  = {CNT_WIDTH{1'b0}};
         loss_cnt_d = 16'd0;
      end else begin
         loss_cnt_d = loss_cnt_d;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!nRESET) begin
         state_q    <= ST_SEARCH;
         sr_q       <= 15'd0;
         fill_q     <= 4'd0;
         match_q    <= 16'd0;
         win_bits_q <= 16'd0;
         win_err_q  <= 16'd0;
         bit_cnt_q  <= {CNT_WIDTH{1'b0}};
         err_cnt_q  <= {CNT_WIDTH{1'b0}};
         loss_cnt_q <= 16'd0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         fill_q     <= fill_d;
         match_q    <= match_d;
         win_bits_q <= win_bits_d;
         win_err_q  <= win_err_d;
         bit_cnt_q  <= bit_cnt_d;
         err_cnt_q  <= err_cnt_d;
         loss_cnt_q <= loss_cnt_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
      end
   end

   assign o_locked   = locked_q;
   assign o_bit_cnt  = bit_cnt_q;
   assign o_err_cnt  = err_cnt_q;
   assign o_loss_cnt = loss_cnt_q;
   assign o_err      = err_q;

endmodule

// File: tb/tb_prs_ber_checker.sv
// Directed bench for prs_ber_checker: PRBS-15 stimulus with a queue of expected
// lock/error flags per driven cycle, plus counter checks at the end of each scenario.
module tb_prs_ber_checker;

   logic        clk = 1'b0;
   logic        nRESET;
   logic        i_clear;
   logic        i_vld;
   logic        i_sym;
   logic        o_locked;
   logic [31:0] o_bit_cnt;
   logic [31:0] o_err_cnt;
   logic [15:0] o_loss_cnt;
   logic        o_err;

   typedef struct packed {
      logic locked;
      logic err;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [14:0] gen_sr;

   prs_ber_checker #(
      .CNT_WIDTH (32),
      .SYNC_LEN  (64),
      .WINDOW_LEN(1024),
      .LOSS_THR  (100)
   ) dut (
      .clk       (clk),
      .nRESET    (nRESET),
      .i_clear   (i_clear),
      .i_vld     (i_vld),
      .i_sym     (i_sym),
      .o_locked  (o_locked),
      .o_bit_cnt (o_bit_cnt),
      .o_err_cnt (o_err_cnt),
      .o_loss_cnt(o_loss_cnt),
      .o_err     (o_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic prbs_bit(output logic b);
      b      = gen_sr[14] ^ gen_sr[13];
      gen_sr = {gen_sr[13:0], b};
   endtask

   task automatic step(input logic vld, input logic sym, input logic clr,
                       input logic exp_lock, input logic exp_err);
      exp_t e;
      i_vld    = vld;
      i_sym    = sym;
      i_clear  = clr;
      e.locked = exp_lock;
      e.err    = exp_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("locked", {31'd0, o_locked}, {31'd0, e.locked});
      chk("err_pulse", {31'd0, o_err}, {31'd0, e.err});
      i_vld   = 1'b0;
      i_clear = 1'b0;
   endtask

   task automatic send(input logic flip, input logic exp_lock, input logic exp_err);
      logic b;
      prbs_bit(b);
      step(1'b1, b ^ flip, 1'b0, exp_lock, exp_err);
   endtask

   task automatic check_cnts(input string tag, input logic [31:0] bits,
                             input logic [31:0] errs, input logic [15:0] losses);
      chk({tag, "_bit_cnt"}, o_bit_cnt, bits);
      chk({tag, "_err_cnt"}, o_err_cnt, errs);
      chk({tag, "_loss_cnt"}, {16'd0, o_loss_cnt}, {16'd0, losses});
   endtask

   task automatic do_reset();
      nRESET = 1'b0;
      i_vld  = 1'b1;
      i_sym  = 1'b1;
      @(posedge clk);
      #1;
      nRESET = 1'b1;
      i_vld  = 1'b0;
      chk("rst_locked", {31'd0, o_locked}, 32'd0);
      chk("rst_err", {31'd0, o_err}, 32'd0);
      check_cnts("rst", 32'd0, 32'd0, 16'd0);
   endtask

   // Clean stream: lock must appear exactly on the 79th valid bit.
   task automatic acquire();
      for (int i = 1; i <= 79; i++) begin
         send(1'b0, i >= 79, 1'b0);
      end
   endtask

   initial begin
      nRESET  = 1'b0;
      i_clear = 1'b0;
      i_vld   = 1'b0;
      i_sym   = 1'b0;
      gen_sr  = 15'h7FFF;

      // Dense clean stream.
      do_reset();
      acquire();
      for (int i = 0; i < 10000; i++) begin
         send(1'b0, 1'b1, 1'b0);
      end
      check_cnts("dense", 32'd10000, 32'd0, 16'd0);

      // Clear with a valid bit in the same cycle.
      begin
         logic b;
         prbs_bit(b);
         step(1'b1, b, 1'b1, 1'b1, 1'b0);
      end
      check_cnts("clear", 32'd0, 32'd0, 16'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0);
      check_cnts("post_clear", 32'd1, 32'd0, 16'd0);

      // Reset while locked, then reacquire at an arbitrary sequence phase.
      do_reset();
      acquire();

      // Two isolated flips at locked bits 500 and 501.
      for (int k = 1; k <= 600; k++) begin
         if (k == 300) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
         end
         send(k == 500 || k == 501, 1'b1, k == 500 || k == 501);
      end
      check_cnts("flips", 32'd600, 32'd2, 16'd0);

      // 200 inverted bits; lock is dropped only at the 1024th locked bit.
      for (int k = 601; k <= 1024; k++) begin
         send(k >= 700 && k <= 899, k < 1024, k >= 700 && k <= 899);
      end
      check_cnts("loss", 32'd1024, 32'd202, 16'd1);

      acquire();
      check_cnts("relock", 32'd1024, 32'd202, 16'd1);

      // Exactly LOSS_THR errors in a window must not drop lock.
      for (int k = 1; k <= 1024; k++) begin
         send(k >= 10 && k <= 109, 1'b1, k >= 10 && k <= 109);
      end
      check_cnts("thr_window", 32'd2048, 32'd302, 16'd1);

      // Sparse valid: one valid bit per 64 cycles with garbage on idle cycles.
      do_reset();
      for (int i = 1; i <= 179; i++) begin
         for (int j = 0; j < 63; j++) begin
            step(1'b0, 1'($urandom()), 1'b0, (i - 1) >= 79, 1'b0);
         end
         send(1'b0, i >= 79, 1'b0);
      end
      check_cnts("sparse", 32'd100, 32'd0, 16'd0);

      // All-zero input never locks.
      do_reset();
      for (int i = 0; i < 5000; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      check_cnts("zeros", 32'd0, 32'd0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
